// File: rtl/led_pwm_pkg.sv
// Register map, address width and field positions of the LED PWM controller.
// Pure constants: no logic, no latency.
// No backpressure: the slave always completes accesses in zero wait states.
package led_pwm_pkg;

  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE  = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE = 4'd8;

  // CTRL fields
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS fields
  localparam int STATUS_IRQ_BIT = 0;
  localparam int STATUS_CNT_LSB = 8;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: pending duty register, active (shadow) duty and output compare.
// pwm_o is registered: it reflects the counter value of the previous cycle.
// No backpressure: writes and shadow loads are accepted every cycle.
module led_pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             duty_wr_i,
  input  logic [CNT_W-1:0] duty_wdat_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] duty_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  // Software writes land in the pending copy; the active copy only moves on a
  // load, so a mid-period write cannot disturb the period in progress.
  always_comb begin
    duty_d     = duty_wr_i ? duty_wdat_i : duty_q;
    duty_act_d = load_i ? duty_q : duty_act_q;
    pwm_d      = enable_i && (cnt_i < duty_act_q);
  end

  // State registers, cleared asynchronously so the LED drops at once on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q     <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Avalon-MM PWM controller for the LED bank: bus decode, prescaler, period counter, irq.
// Zero-wait-state combinational reads; writes visible next cycle; pwm_out 1 clk after cnt.
// No backpressure: the slave never stalls the interconnect.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_CH-1:0]   pwm_out,
  output logic              irq
);

  logic             en_q, en_d;
  logic             en_prev_q;
  logic             irq_en_q, irq_en_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_pend_q, irq_pend_d;

  logic             wr;
  logic             ctrl_wr, prescale_wr, period_wr, status_wr;
  logic             en_rise, tick, wrap, load;
  logic [N_CH-1:0]  duty_wr;
  logic [CNT_W-1:0] duty_pend [N_CH];

  // Bus write decode and the timing events derived from the counters.
  always_comb begin
    wr          = chipselect && !write_n;
    ctrl_wr     = wr && (address == ADDR_CTRL);
    prescale_wr = wr && (address == ADDR_PRESCALE);
    period_wr   = wr && (address == ADDR_PERIOD);
    status_wr   = wr && (address == ADDR_STATUS);
    en_rise     = en_q && !en_prev_q;
    tick        = en_q && (pre_cnt_q == prescale_q);
    wrap        = tick && (cnt_q == period_act_q);
    // Shadows also load on enable rise so the first period uses fresh values.
    load        = wrap || en_rise;
  end

  // Next-state for control registers, counters and the pending interrupt.
  always_comb begin
    en_d         = ctrl_wr ? writedata[CTRL_EN_BIT] : en_q;
    irq_en_d     = ctrl_wr ? writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    prescale_d   = prescale_wr ? writedata[PRE_W-1:0] : prescale_q;
    period_d     = period_wr ? writedata[CNT_W-1:0] : period_q;
    period_act_d = load ? period_q : period_act_q;

    if (!en_q || tick) pre_cnt_d = '0;
    else               pre_cnt_d = pre_cnt_q + PRE_W'(1);

    if (!en_q || wrap) cnt_d = '0;
    else if (tick)     cnt_d = cnt_q + CNT_W'(1);
    else               cnt_d = cnt_q;

    // A wrap in the same cycle as a clear keeps the interrupt pending.
    if (wrap)                                       irq_pend_d = 1'b1;
    else if (status_wr && writedata[STATUS_IRQ_BIT]) irq_pend_d = 1'b0;
    else                                            irq_pend_d = irq_pend_q;
  end

  // Control and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= 1'b0;
      en_prev_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= '0;
      period_q     <= '0;
      period_act_q <= '0;
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      irq_pend_q   <= 1'b0;
    end else begin
      en_q         <= en_d;
      en_prev_q    <= en_q;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      period_q     <= period_d;
      period_act_q <= period_act_d;
      pre_cnt_q    <= pre_cnt_d;
      cnt_q        <= cnt_d;
      irq_pend_q   <= irq_pend_d;
    end
  end

  // Per-channel duty registers and compare.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign duty_wr[gi] = wr && (address == ADDR_DUTY_BASE + ADDR_W'(gi));

    led_pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable_i    (en_q),
      .duty_wr_i   (duty_wr[gi]),
      .duty_wdat_i (writedata[CNT_W-1:0]),
      .load_i      (load),
      .cnt_i       (cnt_q),
      .duty_o      (duty_pend[gi]),
      .pwm_o       (pwm_out[gi])
    );
  end

  // Combinational read mux; unmapped and unpopulated duty slots read zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN_BIT]     = en_q;
        readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_PRESCALE: readdata[PRE_W-1:0] = prescale_q;
      ADDR_PERIOD:   readdata[CNT_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata[STATUS_IRQ_BIT]          = irq_pend_q;
        readdata[STATUS_CNT_LSB +: CNT_W] = cnt_q;
      end
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (address == ADDR_DUTY_BASE + ADDR_W'(i)) readdata[CNT_W-1:0] = duty_pend[i];
        end
      end
    endcase
  end

  assign irq = irq_pend_q && irq_en_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register table plus multi-cycle PWM/irq sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge (or just after).
// Bounded waits everywhere; a global watchdog ends the run if anything stalls.
module tb_led_pwm_ctrl;
  import led_pwm_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  pwm_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  led_pwm_ctrl #(.N_CH(8), .CNT_W(8), .PRE_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic        do_wr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    logic [31:0] r;
    logic        found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      rd(ADDR_STATUS, r);
      if (r[15:8] == v) found = 1'b1;
    end
    chk("wait_cnt", {31'b0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, v1;
    logic        s [40];
    int          h0, h1, h2, per, bad;
    logic        found;

    vecs[0] = '{ADDR_CTRL,      1'b1, 32'hFFFF_FFFE, 32'h0000_0002};
    vecs[1] = '{ADDR_PRESCALE,  1'b1, 32'h0001_ABCD, 32'h0000_ABCD};
    vecs[2] = '{ADDR_PERIOD,    1'b1, 32'h0000_01A5, 32'h0000_00A5};
    vecs[3] = '{ADDR_STATUS,    1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{4'd8,           1'b1, 32'h0000_0137, 32'h0000_0037};
    vecs[5] = '{4'd15,          1'b1, 32'h0000_00FF, 32'h0000_00FF};
    vecs[6] = '{4'd4,           1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{4'd7,           1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{ADDR_CTRL,      1'b0, 32'h0,         32'h0000_0002};
    vecs[9] = '{4'd8,           1'b0, 32'h0,         32'h0000_0037};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), r);
      chk($sformatf("reset_rd[%0d]", a), r, 32'h0);
    end
    chk("reset_pwm", {24'b0, pwm_out}, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // Register write/read table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdat);
      rd(vecs[i].addr, r);
      chk($sformatf("regtab[%0d]", i), r, vecs[i].exp);
    end
    wr(ADDR_CTRL, 0); wr(ADDR_PRESCALE, 0); wr(ADDR_PERIOD, 0);
    wr(4'd8, 0); wr(4'd15, 0);
    chk("disabled_pwm", {24'b0, pwm_out}, 32'h0);

    // PRESCALE=0, PERIOD=9: ch0 3/10, ch1 low, ch2 high
    wr(ADDR_PERIOD, 9); wr(4'd8, 3); wr(4'd9, 0); wr(4'd10, 20);
    wr(ADDR_CTRL, 1);
    repeat (25) @(negedge clk);
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 0; k < 20; k++) begin
      s[k] = pwm_out[0];
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
      @(negedge clk);
    end
    per = 0;
    for (int k = 0; k < 10; k++) if (s[k] != s[k+10]) per++;
    chk("p9_ch0_high", 32'(h0), 32'd6);
    chk("p9_ch1_high", 32'(h1), 32'd0);
    chk("p9_ch2_high", 32'(h2), 32'd20);
    chk("p9_ch0_period", 32'(per), 32'd0);

    // Mid-period duty write: current period unchanged, next period 7 high
    wait_cnt(8'd4);
    wr(4'd8, 7);
    rd(4'd8, r);
    chk("duty_readback", r, 32'd7);
    h0 = 0;
    for (int k = 0; k < 5; k++) begin
      h0 += int'(pwm_out[0]);
      @(negedge clk);
    end
    chk("midwr_cur_period", 32'(h0), 32'd0);
    h0 = 0;
    for (int k = 0; k < 10; k++) begin
      h0 += int'(pwm_out[0]);
      @(negedge clk);
    end
    chk("midwr_next_period", 32'(h0), 32'd7);

    // PRESCALE=3, PERIOD=4, DUTY0=2: 20 clk period, 8 clk high
    wr(ADDR_CTRL, 0); wr(ADDR_PRESCALE, 3); wr(ADDR_PERIOD, 4); wr(4'd8, 2);
    wr(ADDR_CTRL, 1);
    repeat (45) @(negedge clk);
    h0 = 0;
    for (int k = 0; k < 40; k++) begin
      s[k] = pwm_out[0];
      h0 += int'(pwm_out[0]);
      @(negedge clk);
    end
    per = 0;
    for (int k = 0; k < 20; k++) if (s[k] != s[k+20]) per++;
    chk("pre3_high", 32'(h0), 32'd16);
    chk("pre3_period", 32'(per), 32'd0);
    rd(ADDR_STATUS, r);
    v1 = {24'b0, r[15:8]};
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      rd(ADDR_STATUS, r);
      if ({24'b0, r[15:8]} != v1) found = 1'b1;
    end
    chk("pre3_step_seen", {31'b0, found}, 32'd1);
    v1 = {24'b0, r[15:8]};
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd(ADDR_STATUS, r);
      if ({24'b0, r[15:8]} != v1) bad++;
    end
    chk("pre3_cnt_hold", 32'(bad), 32'd0);
    @(negedge clk);
    rd(ADDR_STATUS, r);
    chk("pre3_cnt_step", {24'b0, r[15:8]}, (v1 == 32'd4) ? 32'd0 : v1 + 32'd1);

    // Interrupt behaviour
    wr(ADDR_CTRL, 0); wr(ADDR_PRESCALE, 0); wr(ADDR_PERIOD, 9); wr(4'd8, 3);
    wr(ADDR_STATUS, 1);
    rd(ADDR_STATUS, r);
    chk("irq_pend_cleared", {31'b0, r[0]}, 32'd0);
    wr(ADDR_CTRL, 3);
    chk("irq_low_at_enable", {31'b0, irq}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (irq) found = 1'b1;
    end
    chk("irq_after_wrap", {31'b0, found}, 32'd1);
    rd(ADDR_STATUS, r);
    chk("irq_cnt_at_rise", {24'b0, r[15:8]}, 32'd0);
    wr(ADDR_STATUS, 1);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    wait_cnt(8'd8);
    wr(ADDR_STATUS, 1);
    rd(ADDR_STATUS, r);
    chk("clr_on_wrap_pend", {31'b0, r[0]}, 32'd1);
    chk("clr_on_wrap_irq", {31'b0, irq}, 32'd1);
    wr(ADDR_CTRL, 1);
    chk("irq_en_off", {31'b0, irq}, 32'd0);

    // Disable mid-period, then re-enable
    wait_cnt(8'd5);
    wr(ADDR_CTRL, 0);
    @(negedge clk);
    chk("dis_pwm", {24'b0, pwm_out}, 32'h0);
    rd(ADDR_STATUS, r);
    chk("dis_cnt", {24'b0, r[15:8]}, 32'd0);
    wr(ADDR_CTRL, 1);
    rd(ADDR_STATUS, r);
    chk("reen_cnt0", {24'b0, r[15:8]}, 32'd0);
    @(negedge clk);
    rd(ADDR_STATUS, r);
    chk("reen_cnt1", {24'b0, r[15:8]}, 32'd1);

    // Asynchronous reset mid-period
    wr(ADDR_CTRL, 3);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (irq) found = 1'b1;
    end
    chk("pre_rst_irq", {31'b0, found}, 32'd1);
    repeat (3) @(negedge clk);
    chk("pre_rst_ch2", {31'b0, pwm_out[2]}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pwm", {24'b0, pwm_out}, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    rd(ADDR_CTRL, r);
    chk("arst_ctrl", r, 32'h0);
    rd(ADDR_STATUS, r);
    chk("arst_status", r, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
